if_align: RTL and testbench

Instruction aligner between instruction fetch and decode in the RV32IC pipeline. Consumes the 32-bit aligned words produced by fetch, splits them into 16-bit (compressed) and 32-bit instructions, and reassembles 32-bit instructions that straddle a word boundary. Presents at most one instruction per cycle to decode through a registered valid/ready output. Back-pressures fetch with a combinational stall.

---
 rtl/rv32_pkg.sv | 12 +
 rtl/if_align_if.sv | 24 ++
 rtl/if_align.sv | 120 ++++++++++++
 tb/tb_if_align.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 types and helpers for the front-end pipeline.
package rv32_pkg;

    typedef logic [15:0] half_t;

    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    function automatic logic is_rvc(half_t h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_align_if.sv
// Fetch-side and decode-side signals of the instruction aligner.
interface if_align_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_compressed;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, flush, flush_pc, id_ready,
        input  fetch_stall, id_valid, id_pc, id_instr, id_compressed
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, flush, flush_pc, id_ready,
        output fetch_stall, id_valid, id_pc, id_instr, id_compressed
    );
endinterface

// File: rtl/if_align.sv
// Splits fetched words into RVC / 32-bit instructions and rebuilds
// 32-bit instructions that straddle a word boundary.
module if_align
    import rv32_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    if_align_if.slave  bus
);

    logic        hb_valid_q, hb_valid_d;
    half_t       hb_data_q, hb_data_d;
    logic [31:0] hb_pc_q, hb_pc_d;
    logic        skip_low_q, skip_low_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_comp_q, id_comp_d;

    logic        out_free;
    logic        hb_rvc;
    logic [31:0] word_pc;
    half_t       lo_half;
    half_t       hi_half;
    logic        unused_pc_bits;

    assign out_free = !id_valid_q || bus.id_ready;
    assign hb_rvc   = is_rvc(hb_data_q);
    assign word_pc  = {bus.fetch_pc[31:2], 2'b00};
    assign lo_half  = bus.fetch_instr[15:0];
    assign hi_half  = bus.fetch_instr[31:16];
    assign unused_pc_bits =
        ^{bus.fetch_pc[1:0], bus.flush_pc[31:2], bus.flush_pc[0]};

    assign bus.fetch_stall =
        !bus.flush && (!out_free || (hb_valid_q && hb_rvc));

    always_comb begin
        hb_valid_d = hb_valid_q;
        hb_data_d  = hb_data_q;
        hb_pc_d    = hb_pc_q;
        skip_low_d = skip_low_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_comp_d  = id_comp_q;
        if (bus.flush) begin
            hb_valid_d = 1'b0;
            id_valid_d = 1'b0;
            skip_low_d = bus.flush_pc[1];
        end else if (out_free) begin
            id_valid_d = 1'b0;
            if (hb_valid_q) begin
                if (hb_rvc) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = hb_pc_q;
                    id_instr_d = {16'h0000, hb_data_q};
                    id_comp_d  = 1'b1;
                    hb_valid_d = 1'b0;
                end else if (bus.fetch_valid) begin
                    // upper half of the straddling instruction arrives now
                    id_valid_d = 1'b1;
                    id_pc_d    = hb_pc_q;
                    id_instr_d = {lo_half, hb_data_q};
                    id_comp_d  = 1'b0;
                    hb_data_d  = hi_half;
                    hb_pc_d    = word_pc + 32'd2;
                end
            end else if (bus.fetch_valid) begin
                if (skip_low_q) begin
                    hb_valid_d = 1'b1;
                    hb_data_d  = hi_half;
                    hb_pc_d    = word_pc + 32'd2;
                    skip_low_d = 1'b0;
                end else if (is_rvc(lo_half)) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = word_pc;
                    id_instr_d = {16'h0000, lo_half};
                    id_comp_d  = 1'b1;
                    hb_valid_d = 1'b1;
                    hb_data_d  = hi_half;
                    hb_pc_d    = word_pc + 32'd2;
                end else begin
                    id_valid_d = 1'b1;
                    id_pc_d    = word_pc;
                    id_instr_d = bus.fetch_instr;
                    id_comp_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_valid_q <= 1'b0;
            hb_data_q  <= '0;
            hb_pc_q    <= '0;
            skip_low_q <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
            id_comp_q  <= 1'b0;
        end else begin
            hb_valid_q <= hb_valid_d;
            hb_data_q  <= hb_data_d;
            hb_pc_q    <= hb_pc_d;
            skip_low_q <= skip_low_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_comp_q  <= id_comp_d;
        end
    end

    assign bus.id_valid      = id_valid_q;
    assign bus.id_pc         = id_pc_q;
    assign bus.id_instr      = id_instr_q;
    assign bus.id_compressed = id_comp_q;

endmodule

// File: tb/tb_if_align.sv
// Directed bench for the instruction aligner.
module tb_if_align;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    if_align_if bus();

    if_align dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [31:0] pc, input logic [31:0] w);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        bus.fetch_instr = w;
    endtask

    task automatic idle();
        bus.fetch_valid = 1'b0;
    endtask

    task automatic out(input string tag, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic c);
        chk({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".pc"}, bus.id_pc, pc);
            chk({tag, ".instr"}, bus.id_instr, ins);
            chk({tag, ".comp"}, {31'd0, bus.id_compressed}, {31'd0, c});
        end
    endtask

    task automatic stall(input string tag, input logic s);
        #1;
        chk({tag, ".stall"}, {31'd0, bus.fetch_stall}, {31'd0, s});
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.fetch_pc    = '0;
        bus.fetch_instr = '0;
        bus.flush       = 1'b0;
        bus.flush_pc    = '0;
        bus.id_ready    = 1'b1;
        cyc();
        cyc();
        chk("rst.valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst.pc", bus.id_pc, 32'd0);
        chk("rst.instr", bus.id_instr, 32'd0);
        chk("rst.comp", {31'd0, bus.id_compressed}, 32'd0);
        stall("rst", 1'b0);

        // two aligned 32-bit instructions
        reset_n = 1'b1;
        word(32'h100, 32'h0050_0093);
        stall("w100", 1'b0);
        cyc();
        out("i100", 1'b1, 32'h100, 32'h0050_0093, 1'b0);
        word(32'h104, 32'h00A0_0113);
        stall("w104", 1'b0);
        cyc();
        out("i104", 1'b1, 32'h104, 32'h00A0_0113, 1'b0);
        idle();
        stall("w104b", 1'b0);
        cyc();
        out("idle1", 1'b0, 0, 0, 0);

        // two c.nop in one word
        word(32'h200, 32'h0001_0001);
        stall("w200", 1'b0);
        cyc();
        out("i200", 1'b1, 32'h200, 32'h1, 1'b1);
        idle();
        stall("drain202", 1'b1);
        cyc();
        out("i202", 1'b1, 32'h202, 32'h1, 1'b1);
        stall("after202", 1'b0);

        // straddling 32-bit instruction
        word(32'h300, 32'h0093_0001);
        cyc();
        out("i300", 1'b1, 32'h300, 32'h1, 1'b1);
        stall("hb32", 1'b0);
        word(32'h304, 32'h0001_0050);
        cyc();
        out("i302", 1'b1, 32'h302, 32'h0050_0093, 1'b0);
        idle();
        stall("drain306", 1'b1);
        cyc();
        out("i306", 1'b1, 32'h306, 32'h1, 1'b1);

        // redirect to odd halfword
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h402;
        stall("flush", 1'b0);
        cyc();
        bus.flush = 1'b0;
        out("fl.bub", 1'b0, 0, 0, 0);
        word(32'h400, 32'h0001_0093);
        cyc();
        out("fl.skip", 1'b0, 0, 0, 0);
        idle();
        stall("fl.drain", 1'b1);
        cyc();
        out("i402", 1'b1, 32'h402, 32'h1, 1'b1);

        // decode back-pressure
        bus.id_ready = 1'b0;
        word(32'h500, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            stall("bp", 1'b1);
            cyc();
            out("bp.hold", 1'b1, 32'h402, 32'h1, 1'b1);
        end
        bus.id_ready = 1'b1;
        stall("bp.rel", 1'b0);
        cyc();
        out("i500", 1'b1, 32'h500, 32'h0000_0013, 1'b0);
        idle();
        cyc();
        out("idle2", 1'b0, 0, 0, 0);

        // asynchronous reset with a buffered halfword
        word(32'h600, 32'h0001_0001);
        cyc();
        out("i600", 1'b1, 32'h600, 32'h1, 1'b1);
        idle();
        reset_n = 1'b0;
        #1;
        chk("arst.valid", {31'd0, bus.id_valid}, 32'd0);
        chk("arst.pc", bus.id_pc, 32'd0);
        chk("arst.hb", {31'd0, dut.hb_valid_q}, 32'd0);
        stall("arst", 1'b0);
        cyc();
        reset_n = 1'b1;
        cyc();
        out("arst.nostale", 1'b0, 0, 0, 0);
        word(32'h700, 32'h00A0_0113);
        cyc();
        out("i700", 1'b1, 32'h700, 32'h00A0_0113, 1'b0);

        // flush while decode is stalled drops the pending instruction
        word(32'h800, 32'h0050_0093);
        cyc();
        out("i800", 1'b1, 32'h800, 32'h0050_0093, 1'b0);
        bus.id_ready = 1'b0;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h900;
        idle();
        stall("fl.nrdy", 1'b0);
        cyc();
        bus.flush    = 1'b0;
        bus.id_ready = 1'b1;
        out("fl.drop", 1'b0, 0, 0, 0);
        word(32'h900, 32'h0001_0093);
        cyc();
        out("i900", 1'b1, 32'h900, 32'h0001_0093, 1'b0);
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
